// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: ownership states and default sizing.
package dmem_arbiter_pkg;

  typedef enum logic {
    CPU_OWN  = 1'b0,
    HOST_OWN = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_MAX_WAIT = 4;
  localparam int unsigned DEF_BURST    = 4;

  // Counter width for a 0..n-1 range, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU (default owner) and a host port,
// with a starvation counter that forces a bounded host burst while the CPU is stalled.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned BURST    = DEF_BURST
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_memwrite,
  input  logic          cpu_memread,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_adr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned WCW = cnt_width(MAX_WAIT);
  localparam int unsigned BCW = cnt_width(BURST);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_nxt;
  logic [BCW-1:0] r_beat_cnt;
  logic [BCW-1:0] w_beat_nxt;
  logic           w_cpu_req;
  logic           w_gnt;
  logic           w_stall;
  logic           r_rvalid;
  logic [DW-1:0]  r_rdata;

  assign w_cpu_req = cpu_memwrite | cpu_memread;

  // Ownership state, counters and host read-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= CPU_OWN;
      r_wait_cnt <= '0;
      r_beat_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_rvalid   <= w_gnt & ~host_we;
      if (w_gnt & ~host_we) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // Grant decision and next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_beat_nxt  = r_beat_cnt;
    w_gnt       = 1'b0;
    w_stall     = 1'b0;

    case (r_state)
      CPU_OWN: begin
        w_gnt = host_req & ~w_cpu_req;
        if (host_req & w_cpu_req) begin
          if (r_wait_cnt == WCW'(MAX_WAIT - 1)) begin
            w_state_nxt = HOST_OWN;
            w_wait_nxt  = '0;
          end else begin
            w_wait_nxt = r_wait_cnt + WCW'(1);
          end
        end else if (w_gnt) begin
          w_wait_nxt = '0;
        end
      end
      HOST_OWN: begin
        w_gnt   = host_req;
        w_stall = w_cpu_req & host_req;
        // The burst ends on an idle host cycle or on the last allowed beat
        if (!host_req || (r_beat_cnt == BCW'(BURST - 1))) begin
          w_state_nxt = CPU_OWN;
          w_wait_nxt  = '0;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt = r_beat_cnt + BCW'(1);
        end
      end
      default: begin
        w_state_nxt = CPU_OWN;
      end
    endcase

    if (reset) begin
      w_gnt   = 1'b0;
      w_stall = 1'b0;
    end
  end

  assign host_gnt    = w_gnt;
  assign cpu_stall   = w_stall;
  assign cpu_rdata   = mem_rdata;
  assign host_rvalid = r_rvalid;
  assign host_rdata  = r_rdata;

  // A stalled CPU store must never reach memory
  assign mem_adr   = w_gnt ? host_adr   : cpu_adr;
  assign mem_wdata = w_gnt ? host_wdata : cpu_wdata;
  assign mem_we    = (w_gnt ? host_we : (cpu_memwrite & ~w_stall)) & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int MAX_WAIT = 4;
  localparam int BURST    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_memwrite, cpu_memread;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_adr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] tb_mem [0:255] = '{default: '0};
  logic [DW-1:0] ref_mem [0:255];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Data memory stand-in: asynchronous read, synchronous write
  assign mem_rdata = tb_mem[mem_adr[9:2]];
  always @(posedge clk) if (mem_we) tb_mem[mem_adr[9:2]] <= mem_wdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .BURST(BURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    cpu_memwrite = 0; cpu_memread = 0; cpu_adr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_adr = '0; host_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; idle_inputs();
    host_req = 1; host_we = 1; host_adr = 32'h40; host_wdata = 32'h1234;
    cpu_memwrite = 1; cpu_adr = 32'h44; cpu_wdata = 32'h55;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      n_cmp++; if (host_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt c=%0d got %b exp 0", c, host_gnt); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we c=%0d got %b exp 0", c, mem_we); end
      n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall c=%0d got %b exp 0", c, cpu_stall); end
      if (c > 0) begin
        n_cmp++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid c=%0d got %b exp 0", c, host_rvalid); end
      end
    end
    @(negedge clk);
    reset = 0;
    #2;
    n_cmp++; if (dut.r_state !== CPU_OWN) begin n_fail++; $display("FAIL reset_state got %0d exp CPU_OWN", dut.r_state); end
    n_cmp++; if (host_gnt !== 1'b0 || mem_we !== 1'b1 || mem_adr !== 32'h44)
      begin n_fail++; $display("FAIL reset_release got gnt=%b we=%b adr=%h exp gnt=0 we=1 adr=44", host_gnt, mem_we, mem_adr); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_cpu_store();
    do_reset();
    @(negedge clk);
    cpu_memwrite = 1; cpu_adr = 32'h54; cpu_wdata = 32'd7;
    #2;
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL cpu_store_we got %b exp 1", mem_we); end
    n_cmp++; if (mem_adr !== 32'h54) begin n_fail++; $display("FAIL cpu_store_adr got %h exp 54", mem_adr); end
    n_cmp++; if (mem_wdata !== 32'd7) begin n_fail++; $display("FAIL cpu_store_wdata got %h exp 7", mem_wdata); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_store_stall got %b exp 0", cpu_stall); end
    @(negedge clk);
    cpu_memwrite = 0; cpu_memread = 1; cpu_adr = 32'h54;
    #2;
    n_cmp++; if (cpu_rdata !== 32'd7) begin n_fail++; $display("FAIL cpu_load_data got %h exp 7", cpu_rdata); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL cpu_load_we got %b exp 0", mem_we); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_host_read();
    do_reset();
    @(negedge clk);
    host_req = 1; host_we = 1; host_adr = 32'h10; host_wdata = 32'hDEADBEEF;
    #2;
    n_cmp++; if (host_gnt !== 1'b1 || mem_we !== 1'b1 || mem_adr !== 32'h10)
      begin n_fail++; $display("FAIL host_write got gnt=%b we=%b adr=%h exp 1 1 10", host_gnt, mem_we, mem_adr); end
    @(negedge clk);
    host_we = 0; host_wdata = '0;
    #2;
    n_cmp++; if (host_gnt !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL host_read_gnt got gnt=%b we=%b exp 1 0", host_gnt, mem_we); end
    n_cmp++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_write_rvalid got %b exp 0", host_rvalid); end
    @(negedge clk);
    host_req = 0;
    #2;
    n_cmp++; if (host_rvalid !== 1'b1) begin n_fail++; $display("FAIL host_rvalid got %b exp 1", host_rvalid); end
    n_cmp++; if (host_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL host_rdata got %h exp deadbeef", host_rdata); end
    @(negedge clk);
    #2;
    n_cmp++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_rvalid_pulse got %b exp 0", host_rvalid); end
    n_cmp++; if (host_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL host_rdata_hold got %h exp deadbeef", host_rdata); end
    idle_inputs();
  endtask

  task automatic test_contention();
    logic exp_host;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      cpu_memread = 1; cpu_adr = 32'h54;
      host_req = 1; host_we = 1; host_adr = 32'h80; host_wdata = 32'hA5A5_0000 + 32'(c);
      #2;
      exp_host = (c >= MAX_WAIT) && (c < MAX_WAIT + BURST);
      n_cmp++; if (host_gnt !== exp_host) begin n_fail++; $display("FAIL contend_gnt c=%0d got %b exp %b", c, host_gnt, exp_host); end
      n_cmp++; if (cpu_stall !== exp_host) begin n_fail++; $display("FAIL contend_stall c=%0d got %b exp %b", c, cpu_stall, exp_host); end
      n_cmp++; if (mem_we !== exp_host) begin n_fail++; $display("FAIL contend_we c=%0d got %b exp %b", c, mem_we, exp_host); end
      n_cmp++; if (mem_adr !== (exp_host ? 32'h80 : 32'h54)) begin n_fail++; $display("FAIL contend_adr c=%0d got %h exp %h", c, mem_adr, exp_host ? 32'h80 : 32'h54); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_host_drop();
    logic exp_host;
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      cpu_memread = 1; cpu_adr = 32'h54;
      host_req = (c < 6); host_we = 1; host_adr = 32'h84; host_wdata = 32'h77;
      #2;
      exp_host = (c >= MAX_WAIT) && (c < 6);
      n_cmp++; if (host_gnt !== exp_host || cpu_stall !== exp_host)
        begin n_fail++; $display("FAIL drop_gnt c=%0d got gnt=%b stall=%b exp %b", c, host_gnt, cpu_stall, exp_host); end
      if (c == 6) begin
        n_cmp++; if (mem_adr !== 32'h54 || mem_we !== 1'b0) begin n_fail++; $display("FAIL drop_cpu_served got adr=%h we=%b exp 54 0", mem_adr, mem_we); end
      end
      if (c == 7) begin
        n_cmp++; if (dut.r_state !== CPU_OWN || dut.r_wait_cnt !== '0 || dut.r_beat_cnt !== '0)
          begin n_fail++; $display("FAIL drop_state got st=%0d w=%0d b=%0d exp 0 0 0", dut.r_state, dut.r_wait_cnt, dut.r_beat_cnt); end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_burst();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      reset = (c == 5);
      cpu_memread = 1; cpu_adr = 32'h54;
      host_req = 1; host_we = 0; host_adr = 32'h10;
      #2;
      if (c == 4) begin
        n_cmp++; if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL rb_burst_gnt got %b exp 1", host_gnt); end
      end
      if (c == 5) begin
        n_cmp++; if (host_gnt !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rb_during got gnt=%b stall=%b exp 0 0", host_gnt, cpu_stall); end
      end
      if (c == 6) begin
        n_cmp++; if (dut.r_state !== CPU_OWN) begin n_fail++; $display("FAIL rb_state got %0d exp CPU_OWN", dut.r_state); end
        n_cmp++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rb_rvalid got %b exp 0", host_rvalid); end
        n_cmp++; if (cpu_stall !== 1'b0 || host_gnt !== 1'b0) begin n_fail++; $display("FAIL rb_after got stall=%b gnt=%b exp 0 0", cpu_stall, host_gnt); end
        n_cmp++; if (dut.r_wait_cnt !== '0 || dut.r_beat_cnt !== '0) begin n_fail++; $display("FAIL rb_counters got w=%0d b=%0d exp 0 0", dut.r_wait_cnt, dut.r_beat_cnt); end
      end
    end
    @(negedge clk);
    reset = 0; idle_inputs();
  endtask

  // Random traffic against a model counting denied cycles and remaining window beats
  task automatic test_random();
    bit            host_turn = 0;
    int            denied = 0, beats = 0;
    bit            e_gnt, e_stall, e_we, e_rvalid = 0, creq;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wd, e_rdata = '0, e_crd;
    bit            h_req = 0, h_we = 0;
    logic [AW-1:0] h_adr = '0;
    logic [DW-1:0] h_wd = '0;
    do_reset();
    ref_mem = tb_mem;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      cpu_memwrite = ($urandom_range(0, 9) < 3);
      cpu_memread  = !cpu_memwrite && ($urandom_range(0, 9) < 5);
      cpu_adr      = {22'b0, 8'($urandom), 2'b00};
      cpu_wdata    = $urandom;
      host_req = h_req; host_we = h_we; host_adr = h_adr; host_wdata = h_wd;
      #2;
      creq = cpu_memwrite || cpu_memread;
      e_gnt   = host_turn ? h_req : (h_req && !creq);
      e_stall = host_turn && h_req && creq;
      e_adr   = e_gnt ? h_adr : cpu_adr;
      e_wd    = e_gnt ? h_wd : cpu_wdata;
      e_we    = e_gnt ? h_we : (cpu_memwrite && !e_stall);
      e_crd   = ref_mem[e_adr[9:2]];
      n_cmp++; if (host_gnt !== e_gnt || cpu_stall !== e_stall)
        begin n_fail++; $display("FAIL rnd_arb c=%0d got gnt=%b stall=%b exp %b %b", c, host_gnt, cpu_stall, e_gnt, e_stall); end
      n_cmp++; if (mem_we !== e_we || mem_adr !== e_adr || (e_we && mem_wdata !== e_wd))
        begin n_fail++; $display("FAIL rnd_mem c=%0d got we=%b adr=%h wd=%h exp %b %h %h", c, mem_we, mem_adr, mem_wdata, e_we, e_adr, e_wd); end
      n_cmp++; if (cpu_rdata !== e_crd) begin n_fail++; $display("FAIL rnd_cpu_rdata c=%0d got %h exp %h", c, cpu_rdata, e_crd); end
      n_cmp++; if (host_rvalid !== e_rvalid || host_rdata !== e_rdata)
        begin n_fail++; $display("FAIL rnd_host_ret c=%0d got v=%b d=%h exp %b %h", c, host_rvalid, host_rdata, e_rvalid, e_rdata); end
      e_rvalid = e_gnt && !h_we;
      if (e_rvalid) e_rdata = ref_mem[h_adr[9:2]];
      if (e_we) ref_mem[e_adr[9:2]] = e_wd;
      if (!host_turn) begin
        if (h_req && creq) begin
          denied++;
          if (denied == MAX_WAIT) begin host_turn = 1; denied = 0; end
        end else if (e_gnt) denied = 0;
      end else if (!h_req) begin
        host_turn = 0; denied = 0; beats = 0;
      end else begin
        beats++;
        if (beats == BURST) begin host_turn = 0; beats = 0; denied = 0; end
      end
      if (!h_req || e_gnt) begin
        h_req = ($urandom_range(0, 9) < 7);
        h_we  = $urandom_range(0, 1) == 1;
        h_adr = {22'b0, 8'($urandom), 2'b00};
        h_wd  = $urandom;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_cpu_store();
    test_host_read();
    test_contention();
    test_host_drop();
    test_reset_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
